// File: rtl/demod_integrator.sv
// rtl/demod_integrator.sv - windowed I/Q integrator: sums NUM_LANES rotated lanes over sample_length cycles
module demod_integrator #(
  parameter int NUM_LANES = 5,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 11,
  parameter int ACC_W     = 32
) (
  input  logic                          clk100,
  input  logic                          reset,
  input  logic                          start_collect,
  input  logic [LEN_W-1:0]              sample_length,
  input  logic [NUM_LANES*DATA_W-1:0]   data_i_rot,
  input  logic [NUM_LANES*DATA_W-1:0]   data_q_rot,
  output logic                          busy,
  output logic                          result_valid,
  output logic signed [ACC_W-1:0]       result_i,
  output logic signed [ACC_W-1:0]       result_q,
  output logic [15:0]                   shot_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LEN_W-1:0]        remain;
  logic                    lane_vld;
  logic signed [ACC_W-1:0] lane_sum_i;
  logic signed [ACC_W-1:0] lane_sum_q;
  logic signed [ACC_W-1:0] lane_sum_i_nxt;
  logic signed [ACC_W-1:0] lane_sum_q_nxt;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic [DATA_W-1:0]       lane_i;
  logic [DATA_W-1:0]       lane_q;
  logic                    start_ok;

  assign start_ok = (state == IDLE) && start_collect;

  always_comb begin
    lane_sum_i_nxt = '0;
    lane_sum_q_nxt = '0;
    lane_i         = '0;
    lane_q         = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_i = data_i_rot[k*DATA_W +: DATA_W];
      lane_q = data_q_rot[k*DATA_W +: DATA_W];
      lane_sum_i_nxt = lane_sum_i_nxt + {{(ACC_W-DATA_W){lane_i[DATA_W-1]}}, lane_i};
      lane_sum_q_nxt = lane_sum_q_nxt + {{(ACC_W-DATA_W){lane_q[DATA_W-1]}}, lane_q};
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start_collect) state_nxt = (sample_length == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (remain == LEN_W'(1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state      <= IDLE;
      remain     <= '0;
      lane_vld   <= 1'b0;
      lane_sum_i <= '0;
      lane_sum_q <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      result_i   <= '0;
      result_q   <= '0;
      shot_count <= '0;
    end else begin
      state    <= state_nxt;
      lane_vld <= (state == COLLECT);
      if (state == COLLECT) begin
        lane_sum_i <= lane_sum_i_nxt;
        lane_sum_q <= lane_sum_q_nxt;
        remain     <= remain - LEN_W'(1);
      end
      if (start_ok) begin
        remain <= sample_length;
        acc_i  <= '0;
        acc_q  <= '0;
      end else if (lane_vld) begin
        acc_i <= acc_i + lane_sum_i;
        acc_q <= acc_q + lane_sum_q;
      end
      // The last lane sum is still in flight during FLUSH, so fold it in here.
      if (state_nxt == DONE) begin
        result_i   <= (state == FLUSH) ? acc_i + lane_sum_i : '0;
        result_q   <= (state == FLUSH) ? acc_q + lane_sum_q : '0;
        shot_count <= shot_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_demod_integrator.sv
// tb/tb_demod_integrator.sv - randomized self-checking bench for demod_integrator
module tb_demod_integrator;
  localparam int NL = 5;
  localparam int DW = 16;
  localparam int LW = 11;
  localparam int AW = 32;

  logic                 clk100 = 1'b0;
  logic                 reset;
  logic                 start_collect;
  logic [LW-1:0]        sample_length;
  logic [NL*DW-1:0]     data_i_rot;
  logic [NL*DW-1:0]     data_q_rot;
  logic                 busy;
  logic                 result_valid;
  logic signed [AW-1:0] result_i;
  logic signed [AW-1:0] result_q;
  logic [15:0]          shot_count;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          prev_rv_cyc = -1;
  longint      cur_si, cur_sq;
  longint      last_i = 0, last_q = 0;
  logic [15:0] shot_exp = '0;

  demod_integrator dut (
    .clk100(clk100), .reset(reset), .start_collect(start_collect),
    .sample_length(sample_length), .data_i_rot(data_i_rot), .data_q_rot(data_q_rot),
    .busy(busy), .result_valid(result_valid), .result_i(result_i),
    .result_q(result_q), .shot_count(shot_count)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
    cyc++;
  endtask

  // mode 0 random, 1 +1/-1, 2 full scale, 3 ramp 8*cycle+lane
  task automatic drive(input int mode);
    cur_si = 0;
    cur_sq = 0;
    for (int k = 0; k < NL; k++) begin
      logic signed [DW-1:0] vi, vq;
      case (mode)
        1:       begin vi = 16'sd1;     vq = -16'sd1;     end
        2:       begin vi = 16'sh7fff;  vq = 16'sh8000;   end
        3:       begin vi = DW'(8*cyc + k); vq = DW'(-(8*cyc + k)); end
        default: begin vi = DW'($urandom); vq = DW'($urandom); end
      endcase
      data_i_rot[k*DW +: DW] = vi;
      data_q_rot[k*DW +: DW] = vq;
      cur_si += vi;
      cur_sq += vq;
    end
  endtask

  task automatic run_window(input int n, input int mode, input bit hold, input bit pulse);
    longint si = 0, sq = 0;
    start_collect = 1'b1;
    sample_length = LW'(n);
    drive(0);
    step();
    if (!hold) start_collect = 1'b0;
    sample_length = LW'($urandom);
    for (int c = 1; c <= n; c++) begin
      drive(mode);
      si += cur_si;
      sq += cur_sq;
      if (pulse && !hold) start_collect = 1'($urandom);
      @(negedge clk100);
      check("busy_collect", busy, 1);
      check("rv_collect", result_valid, 0);
      step();
    end
    if (n != 0) begin
      drive(mode);
      if (pulse && !hold) start_collect = 1'($urandom);
      @(negedge clk100);
      check("busy_flush", busy, 1);
      check("rv_flush", result_valid, 0);
      step();
    end
    drive(0);
    @(negedge clk100);
    shot_exp = shot_exp + 16'd1;
    check("rv_done", result_valid, 1);
    check("busy_done", busy, 0);
    check("result_i", result_i, si);
    check("result_q", result_q, sq);
    check("shot_count", shot_count, shot_exp);
    if (hold && prev_rv_cyc >= 0) check("period", cyc - prev_rv_cyc, (n == 0) ? 2 : n + 3);
    prev_rv_cyc = cyc;
    last_i = si;
    last_q = sq;
    step();
    if (!hold) start_collect = 1'b0;
  endtask

  task automatic idle(input int k);
    start_collect = 1'b0;
    for (int c = 0; c < k; c++) begin
      drive(0);
      @(negedge clk100);
      check("rv_idle", result_valid, 0);
      check("busy_idle", busy, 0);
      check("held_i", result_i, last_i);
      check("held_q", result_q, last_q);
      check("shot_idle", shot_count, shot_exp);
      step();
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start_collect = 1'b1;
    sample_length = LW'(5);
    drive(0);
    step();
    step();
    @(negedge clk100);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_i", result_i, 0);
    check("rst_q", result_q, 0);
    check("rst_shot", shot_count, 0);
    start_collect = 1'b0;
    step();
    reset = 1'b0;
    idle(2);

    run_window(4, 1, 0, 0);
    idle(2);
    run_window(3, 3, 0, 0);
    idle(1);
    run_window(0, 0, 0, 0);
    idle(1);
    run_window(2000, 2, 0, 0);
    idle(1);

    prev_rv_cyc = -1;
    for (int w = 0; w < 3; w++) run_window(3, 0, 1, 0);
    idle(2);

    for (int w = 0; w < 8; w++) begin
      run_window(int'($urandom_range(0, 20)), 0, 0, 1);
      if ($urandom_range(0, 1) == 1) idle(1);
    end

    start_collect = 1'b1;
    sample_length = LW'(10);
    drive(0);
    step();
    start_collect = 1'b0;
    drive(0);
    step();
    reset = 1'b1;
    drive(0);
    step();
    reset = 1'b0;
    shot_exp = '0;
    last_i = 0;
    last_q = 0;
    @(negedge clk100);
    check("mid_rst_rv", result_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_i", result_i, 0);
    check("mid_rst_q", result_q, 0);
    check("mid_rst_shot", shot_count, 0);
    step();
    idle(15);
    run_window(5, 0, 0, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
